// File: rtl/twiddle_pkg.sv
// Shared types and elaboration-time helpers for the twiddle-factor generator:
// FSM state encoding, width helpers and the quarter-wave sine table builder.
package twiddle_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    localparam real PI = 3.14159265358979323846;

    // Width of the stage index port for an n-point transform.
    function automatic int stage_w(int n);
        return $clog2($clog2(n));
    endfunction

    // Address width needed to reach all n/4+1 quarter-table entries.
    function automatic int addr_w(int n);
        return $clog2(n / 4 + 1);
    endfunction

    // Q[i] = round(sin(2*pi*i/n) * 2^frac_w); non-negative over the quarter wave.
    function automatic int qsin(int n, int frac_w, int i);
        real x;
        x = $sin(2.0 * PI * real'(i) / real'(n)) * (2.0 ** real'(frac_w));
        return $rtoi(x + 0.5);
    endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Quarter-wave sine table with two synchronous read ports sharing one enable.
// No reset, so the table and read registers can map onto ROM/LUT resources.
module twiddle_qrom
    import twiddle_pkg::*;
#(
    parameter int N_POINTS = 64,
    parameter int FRAC_W   = 8,
    parameter int AW       = 5,
    parameter int QW       = 9
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] cos_addr,
    input  logic [AW-1:0] sin_addr,
    output logic [QW-1:0] cos_data,
    output logic [QW-1:0] sin_data
);

    localparam int DEPTH = N_POINTS / 4 + 1;

    logic [QW-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = QW'(qsin(N_POINTS, FRAC_W, i));
    end

    always_ff @(posedge clk) begin
        if (en) begin
            cos_data <= rom[cos_addr];
            sin_data <= rom[sin_addr];
        end
    end

endmodule

// File: rtl/twiddle_gen.sv
// Streams the twiddle factors of one radix-2 FFT/IFFT stage per start, built from a
// quarter-wave sine table with symmetry logic, through a 3-stage stallable pipeline.
module twiddle_gen
    import twiddle_pkg::*;
#(
    parameter int N_POINTS = 64,
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int LOG2N    = $clog2(N_POINTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [stage_w(N_POINTS)-1:0]  stage,
    input  logic                          inverse,
    output logic                          busy,
    output logic [DATA_W-1:0]             tw_re,
    output logic [DATA_W-1:0]             tw_im,
    output logic                          tw_valid,
    input  logic                          tw_ready,
    output logic                          tw_last,
    output logic                          done
);

    localparam int SW = stage_w(N_POINTS);
    localparam int AW = addr_w(N_POINTS);
    localparam int QW = FRAC_W + 1;

    localparam logic [AW-1:0] QA      = AW'(N_POINTS / 4);
    localparam logic [AW-1:0] ONE     = AW'(1);
    localparam logic [SW:0]   NSTAGES = (SW + 1)'(LOG2N);
    localparam logic [SW-1:0] SMAX    = SW'(LOG2N - 1);

    // Reset asserts asynchronously but is released in step with clk.
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_int = rst_sync_q[1];

    state_e          state_q, state_d;
    logic            en, hs_last, stage_ok, accept, issue, at_last;
    logic [AW-1:0]   j_q, last_j, k, kp;
    logic [SW-1:0]   stage_q, shamt;
    logic            inv_q;

    assign en       = !tw_valid || tw_ready;
    assign hs_last  = tw_valid && tw_ready && tw_last;
    assign stage_ok = {1'b0, stage} < NSTAGES;
    // For s = LOG2N-1 the shift wraps to zero, giving the all-ones last index.
    assign last_j   = (ONE << stage_q) - ONE;
    assign at_last  = j_q == last_j;
    assign shamt    = SMAX - stage_q;
    assign k        = j_q << shamt;

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start && stage_ok) state_d = StRun;
            StRun:   if (en && at_last)     state_d = StDrain;
            StDrain: if (hs_last)           state_d = StIdle;
            default:                        state_d = StIdle;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        accept = 1'b0;
        issue  = 1'b0;
        unique case (state_q)
            StIdle:  accept = start && stage_ok;
            StRun: begin
                busy  = 1'b1;
                issue = en;
            end
            StDrain: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            j_q     <= '0;
            stage_q <= '0;
            inv_q   <= 1'b0;
        end else if (accept) begin
            j_q     <= '0;
            stage_q <= stage;
            inv_q   <= inverse;
        end else if (issue) begin
            j_q     <= j_q + ONE;
        end
    end

    // P0: fold k in [0, N/2) onto the quarter table.
    logic [AW-1:0] cos_addr_d, sin_addr_d;
    logic          neg_d;

    always_comb begin
        kp = k - QA;
        if (k <= QA) begin
            cos_addr_d = QA - k;
            sin_addr_d = k;
            neg_d      = 1'b0;
        end else begin
            cos_addr_d = kp;
            sin_addr_d = QA - kp;
            neg_d      = 1'b1;
        end
    end

    logic          p0_valid, p0_last, p0_neg;
    logic [AW-1:0] p0_cos_addr, p0_sin_addr;
    logic          p1_valid, p1_last, p1_neg;

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            p0_valid    <= 1'b0;
            p0_last     <= 1'b0;
            p0_neg      <= 1'b0;
            p0_cos_addr <= '0;
            p0_sin_addr <= '0;
            p1_valid    <= 1'b0;
            p1_last     <= 1'b0;
            p1_neg      <= 1'b0;
        end else if (en) begin
            p0_valid    <= issue;
            p0_last     <= issue && at_last;
            p0_neg      <= neg_d;
            p0_cos_addr <= cos_addr_d;
            p0_sin_addr <= sin_addr_d;
            p1_valid    <= p0_valid;
            p1_last     <= p0_last;
            p1_neg      <= p0_neg;
        end
    end

    // P1: registered table read.
    logic [QW-1:0] rom_cos, rom_sin;

    twiddle_qrom #(
        .N_POINTS (N_POINTS),
        .FRAC_W   (FRAC_W),
        .AW       (AW),
        .QW       (QW)
    ) u_qrom (
        .clk      (clk),
        .en       (en),
        .cos_addr (p0_cos_addr),
        .sin_addr (p0_sin_addr),
        .cos_data (rom_cos),
        .sin_data (rom_sin)
    );

    // P2: sign handling; magnitudes never exceed 2^FRAC_W so negation is exact.
    logic [DATA_W-1:0] cos_ext, sin_ext, re_d, im_d;

    assign cos_ext = {{(DATA_W - QW){1'b0}}, rom_cos};
    assign sin_ext = {{(DATA_W - QW){1'b0}}, rom_sin};
    assign re_d    = p1_neg ? -cos_ext : cos_ext;
    assign im_d    = inv_q ? sin_ext : -sin_ext;

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            tw_valid <= 1'b0;
            tw_last  <= 1'b0;
            tw_re    <= '0;
            tw_im    <= '0;
            done     <= 1'b0;
        end else begin
            done <= hs_last;
            if (en) begin
                tw_valid <= p1_valid;
                tw_last  <= p1_valid && p1_last;
                if (p1_valid) begin
                    tw_re <= re_d;
                    tw_im <= im_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_twiddle_gen.sv
// Directed self-checking bench for twiddle_gen at N=64, DATA_W=16, FRAC_W=8.
module tb_twiddle_gen;

    logic        clk = 1'b0;
    logic        rst_n, start, inverse, tw_ready;
    logic [2:0]  stage;
    logic        busy, tw_valid, tw_last, done;
    logic [15:0] tw_re, tw_im;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [15:0] exp_re [32];
    logic [15:0] exp_im [32];

    twiddle_gen #(
        .N_POINTS (64),
        .DATA_W   (16),
        .FRAC_W   (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stage    (stage),
        .inverse  (inverse),
        .busy     (busy),
        .tw_re    (tw_re),
        .tw_im    (tw_im),
        .tw_valid (tw_valid),
        .tw_ready (tw_ready),
        .tw_last  (tw_last),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd(real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    // Golden values straight from cos/sin, independent of the table folding.
    task automatic fill_model(input int s, input bit inv);
        for (int j = 0; j < (1 << s); j++) begin
            int  kk;
            int  sv;
            real a;
            kk = j << (5 - s);
            a  = 2.0 * 3.14159265358979323846 * real'(kk) / 64.0;
            sv = rnd($sin(a) * 256.0);
            exp_re[j] = 16'(rnd($cos(a) * 256.0));
            exp_im[j] = inv ? 16'(sv) : 16'(-sv);
        end
    endtask

    // Runs one stage; returns on the cycle done is expected high.
    task automatic run_stream(input int s, input bit inv, input bit rnd_ready, input bit poke);
        int          n;
        int          beats;
        int          cyc;
        bit          seen;
        bit          stalled;
        bit          r;
        logic [15:0] sre, sim;
        logic        slast;
        n       = 1 << s;
        beats   = 0;
        cyc     = 0;
        seen    = 1'b0;
        stalled = 1'b0;
        sre     = '0;
        sim     = '0;
        slast   = 1'b0;
        start   = 1'b1;
        stage   = 3'(s);
        inverse = inv;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("done_single_cycle", done, 0);
        while (cyc < 1000) begin
            start = poke && (cyc == 2);
            if (start) begin
                stage   = 3'd1;
                inverse = ~inv;
            end
            r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tw_ready = r;
            if (stalled) begin
                check("stall_valid", tw_valid, 1);
                check("stall_re", tw_re, sre);
                check("stall_im", tw_im, sim);
                check("stall_last", tw_last, slast);
            end
            if (tw_valid && !seen) begin
                seen = 1'b1;
                check("first_beat_latency", cyc, 3);
            end
            if (tw_valid && r) begin
                check("beat_re", tw_re, exp_re[beats]);
                check("beat_im", tw_im, exp_im[beats]);
                check("beat_last", tw_last, beats == n - 1);
                beats++;
                if (beats == n) begin
                    start = 1'b0;
                    tick();
                    check("done_pulse", done, 1);
                    check("busy_low_with_done", busy, 0);
                    check("no_extra_beat", tw_valid, 0);
                    return;
                end
            end
            stalled = tw_valid && !r;
            sre     = tw_re;
            sim     = tw_im;
            slast   = tw_last;
            tick();
            cyc++;
        end
        start = 1'b0;
        check("stream_timeout_beats", beats, n);
    endtask

    initial begin
        int beats;
        int cyc;

        rst_n    = 1'b0;
        start    = 1'b0;
        stage    = '0;
        inverse  = 1'b0;
        tw_ready = 1'b1;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_valid", tw_valid, 0);
        check("rst_last", tw_last, 0);
        check("rst_done", done, 0);
        check("rst_re", tw_re, 0);
        check("rst_im", tw_im, 0);
        rst_n = 1'b1;
        repeat (4) tick();

        // s=0: single beat carrying tw_last.
        exp_re[0] = 16'h0100; exp_im[0] = 16'h0000;
        run_stream(0, 1'b0, 1'b0, 1'b0);
        tick();

        // s=1 forward, then inverse started on the done cycle.
        exp_re[0] = 16'h0100; exp_im[0] = 16'h0000;
        exp_re[1] = 16'h0000; exp_im[1] = 16'hFF00;
        run_stream(1, 1'b0, 1'b0, 1'b0);
        exp_im[1] = 16'h0100;
        run_stream(1, 1'b1, 1'b0, 1'b0);

        // s=2 forward, also back-to-back.
        exp_re[0] = 16'h0100; exp_im[0] = 16'h0000;
        exp_re[1] = 16'h00B5; exp_im[1] = 16'hFF4B;
        exp_re[2] = 16'h0000; exp_im[2] = 16'hFF00;
        exp_re[3] = 16'hFF4B; exp_im[3] = 16'hFF4B;
        run_stream(2, 1'b0, 1'b0, 1'b0);
        tick();

        // Out-of-range stage is ignored.
        start = 1'b1;
        stage = 3'd6;
        tick();
        start = 1'b0;
        check("bad_stage_busy", busy, 0);
        repeat (4) tick();
        check("bad_stage_valid", tw_valid, 0);
        check("bad_stage_busy_later", busy, 0);

        // s=5 with random backpressure and a start poked mid-run.
        fill_model(5, 1'b0);
        run_stream(5, 1'b0, 1'b1, 1'b1);
        fill_model(3, 1'b1);
        run_stream(3, 1'b1, 1'b1, 1'b0);
        tick();

        // Reset after the 10th beat of an s=5 run.
        fill_model(5, 1'b0);
        tw_ready = 1'b1;
        start    = 1'b1;
        stage    = 3'd5;
        inverse  = 1'b0;
        tick();
        start = 1'b0;
        beats = 0;
        cyc   = 0;
        while (beats < 10 && cyc < 100) begin
            if (tw_valid) beats++;
            tick();
            cyc++;
        end
        check("midrst_reach_beat10", beats, 10);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", tw_valid, 0);
        check("midrst_re", tw_re, 0);
        check("midrst_im", tw_im, 0);
        check("midrst_last", tw_last, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_no_done", done, 0);
        end
        run_stream(5, 1'b0, 1'b0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
